// File: rtl/edge_event_pkg.sv
// Shared types for the edge event arbiter: FSM state encoding and ID width helper.
package edge_event_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic int id_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Control, level and event-handshake bundle between a source/consumer and edge_event_arbiter.
interface edge_event_arbiter_if
  import edge_event_pkg::*;
#(
  parameter int Width = 4,
  parameter int ID_W  = id_width(Width)
) ();

  logic             enable;
  logic [Width-1:0] Level_In;
  logic             clear_pending;
  logic             Event_Ready;
  logic             Overflow_Clr;
  logic             Event_Valid;
  logic [ID_W-1:0]  Event_Id;
  logic [Width-1:0] Pending;
  logic [Width-1:0] Overflow;

  modport master (
    output enable, Level_In, clear_pending, Event_Ready, Overflow_Clr,
    input  Event_Valid, Event_Id, Pending, Overflow
  );

  modport slave (
    input  enable, Level_In, clear_pending, Event_Ready, Overflow_Clr,
    output Event_Valid, Event_Id, Pending, Overflow
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping to bit 0.
module rr_pick
  import edge_event_pkg::*;
#(
  parameter int Width = 4,
  parameter int ID_W  = id_width(Width)
) (
  input  logic [Width-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic            hi_found, lo_found;
  logic [ID_W-1:0] hi_idx, lo_idx;

  // Two constant-index scans avoid a variable rotate; the upper scan wins when it hits.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < Width; i++) begin
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (req[i] && !hi_found && (i >= int'(ptr))) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
  end

  assign any = lo_found;
  assign idx = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns rising edges on level inputs into round-robin event IDs; pending set to valid is 1 cycle,
// an offer holds until Ready (or clear_pending aborts it), with one IDLE bubble per event.
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int Width = 4,
  parameter int ID_W  = id_width(Width)
) (
  input logic                 clk,
  input logic                 ares_n,
  edge_event_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [Width-1:0] lvl_q, pend_q, pend_d, ovf_q, ovf_d;
  logic [Width-1:0] edge_det, clr_mask;
  logic [ID_W-1:0]  id_q, id_d, ptr_q, ptr_d, pick_idx;
  logic             pick_any, hs;

  assign edge_det = bus.Level_In & ~lvl_q & {Width{bus.enable}};
  assign hs       = (state_q == OFFER) && bus.Event_Ready;
  assign clr_mask = hs ? (Width'(1) << id_q) : '0;

  // A fresh edge always re-arms its flag; a completing handshake suppresses the overflow.
  assign pend_d = edge_det | (pend_q & ~clr_mask & ~{Width{bus.clear_pending}});
  assign ovf_d  = (edge_det & pend_q & ~clr_mask) | (bus.Overflow_Clr ? '0 : ovf_q);

  rr_pick #(
    .Width (Width),
    .ID_W  (ID_W)
  ) u_pick (
    .req (pend_q),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !bus.clear_pending) begin
          id_d    = pick_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          ptr_d   = (id_q == ID_W'(Width - 1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end else if (bus.clear_pending) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ares_n) begin
    if (!ares_n) begin
      state_q <= IDLE;
      lvl_q   <= '1;
      pend_q  <= '0;
      ovf_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= bus.Level_In;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.Event_Valid = (state_q == OFFER);
  assign bus.Event_Id    = id_q;
  assign bus.Pending     = pend_q;
  assign bus.Overflow    = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (Width=4) with hand-computed expectations.
module tb_edge_event_arbiter;

  logic clk;
  logic ares_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  edge_event_arbiter_if #(.Width(4)) bus ();

  edge_event_arbiter #(.Width(4)) dut (
    .clk    (clk),
    .ares_n (ares_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vp(input string tag, input logic v, input logic [3:0] p);
    chk({tag, "_vld"}, 32'(bus.Event_Valid), 32'(v));
    chk({tag, "_pend"}, 32'(bus.Pending), 32'(p));
  endtask

  task automatic chk_id(input string tag, input logic [1:0] id);
    chk({tag, "_vld"}, 32'(bus.Event_Valid), 32'h1);
    chk({tag, "_id"}, 32'(bus.Event_Id), 32'(id));
  endtask

  task automatic chk_ovf(input string tag, input logic [3:0] o);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'(o));
  endtask

  initial begin
    ares_n            = 1'b0;
    bus.enable        = 1'b1;
    bus.Level_In      = 4'hF;
    bus.clear_pending = 1'b0;
    bus.Event_Ready   = 1'b1;
    bus.Overflow_Clr  = 1'b0;
    #1;
    chk_vp("rst", 1'b0, 4'h0);
    chk("rst_id", 32'(bus.Event_Id), 32'h0);
    chk_ovf("rst", 4'h0);
    #11 ares_n = 1'b1;

    // Inputs high through reset release: no events
    step(); step(); step();
    chk_vp("held_hi", 1'b0, 4'h0);

    // Round robin from ptr=0: inputs 0,1,3 together
    bus.Level_In = 4'b0000; step();
    bus.Level_In = 4'b1011; step();
    chk_vp("rr_set", 1'b0, 4'b1011);
    step(); chk_id("rr_0", 2'd0);
    step(); chk_vp("rr_gap0", 1'b0, 4'b1010);
    step(); chk_id("rr_1", 2'd1);
    step(); chk_vp("rr_gap1", 1'b0, 4'b1000);
    step(); chk_id("rr_3", 2'd3);
    step(); chk_vp("rr_done", 1'b0, 4'b0000);
    // ptr wrapped to 0: re-raised input 0 served next
    bus.Level_In = 4'b1010; step();
    bus.Level_In = 4'b1011; step();
    chk_vp("rr_re0", 1'b0, 4'b0001);
    step(); chk_id("rr_re0", 2'd0);
    step(); chk_vp("rr_re0_done", 1'b0, 4'b0000);

    // Basic path on input 2
    bus.Level_In = 4'b0000; step();
    bus.Level_In = 4'b0100; step();
    chk_vp("basic_k", 1'b0, 4'b0100);
    step(); chk_id("basic_k1", 2'd2);
    step(); chk_vp("basic_k2", 1'b0, 4'b0000);

    // Backpressure: Id 1 offered (ptr=3 wraps to 1), Ready low 5 cycles
    bus.Event_Ready = 1'b0;
    bus.Level_In    = 4'b0110; step();
    chk_vp("bp_set", 1'b0, 4'b0010);
    step(); chk_id("bp_offer", 2'd1);
    bus.Level_In = 4'b0100; step(); chk_id("bp_s1", 2'd1);
    bus.Level_In = 4'b0110; step(); chk_id("bp_s2", 2'd1);
    chk_ovf("bp_s2", 4'b0010);
    chk("bp_s2_pend", 32'(bus.Pending), 32'h2);
    bus.Level_In = 4'b0100; step(); chk_id("bp_s3", 2'd1);
    bus.Overflow_Clr = 1'b1; step(); chk_id("bp_s4", 2'd1);
    chk_ovf("bp_clr", 4'b0000);
    bus.Overflow_Clr = 1'b0; step(); chk_id("bp_s5", 2'd1);
    // Edge on input 1 coincident with its handshake
    bus.Level_In = 4'b0110; bus.Event_Ready = 1'b1; step();
    chk_vp("bp_hs_edge", 1'b0, 4'b0010);
    chk_ovf("bp_hs_edge", 4'b0000);
    step(); chk_id("bp_again", 2'd1);
    step(); chk_vp("bp_again_done", 1'b0, 4'b0000);

    // Enable gating: input 3 rises while disabled, stays high after enabling
    bus.Level_In = 4'b0000; step();
    bus.enable = 1'b0; bus.Level_In = 4'b1000; step();
    step();
    bus.enable = 1'b1; step(); step();
    chk_vp("en_gate", 1'b0, 4'b0000);

    // Abort of an offer of Id 2 (ptr=2)
    bus.Event_Ready = 1'b0;
    bus.Level_In    = 4'b1100; step();
    chk_vp("ab_set", 1'b0, 4'b0100);
    step(); chk_id("ab_offer", 2'd2);
    bus.clear_pending = 1'b1; step();
    chk_vp("ab_abort", 1'b0, 4'b0000);
    bus.clear_pending = 1'b0;
    // Pointer unchanged at 2: of {0,2}, 2 wins
    bus.Level_In = 4'b0000; step();
    bus.Level_In = 4'b0101; step();
    chk_vp("ab_ptr_set", 1'b0, 4'b0101);
    step(); chk_id("ab_ptr", 2'd2);
    // New overflow wins over Overflow_Clr
    bus.Level_In = 4'b0100; step();
    bus.Level_In = 4'b0101; bus.Overflow_Clr = 1'b1; step();
    chk_ovf("ovf_vs_clr", 4'b0001);
    chk_id("ovf_vs_clr", 2'd2);
    bus.Overflow_Clr = 1'b0;

    // Async reset between edges while offering
    #2 ares_n = 1'b0;
    #1;
    chk_vp("arst", 1'b0, 4'h0);
    chk("arst_id", 32'(bus.Event_Id), 32'h0);
    chk_ovf("arst", 4'h0);
    #1 ares_n = 1'b1;
    bus.Event_Ready = 1'b1;
    bus.Level_In    = 4'b0000; step();
    bus.Level_In    = 4'b0100; step();
    chk_vp("post_k", 1'b0, 4'b0100);
    step(); chk_id("post_k1", 2'd2);
    step(); chk_vp("post_k2", 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Converts leading edges on `Width` level inputs into a serialized stream of event IDs for a single downstream consumer, using a valid/ready handshake. Each input keeps one pending flag, and the pending inputs are served round-robin. An edge that arrives on an input whose flag is already set raises a sticky overflow flag for that input. The block sits between asynchronous status levels (already synchronized) and a shared event-handling engine, and shares that engine fairly among the sources.

## Interface
- `Width`, default 4: number of level inputs (1 or more).
- `ID_W`, default clog2(`Width`) with a minimum of 1: width of `Event_Id`.

- `clk` in 1: the block's single clock, rising edge.
- `ares_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: when high, edges are captured; when low, edges are ignored.
- `Level_In` in `Width`: level inputs, already synchronous to `clk`.
- `clear_pending` in 1: synchronous pulse that clears all pending flags and aborts any offer in progress.
- `Event_Ready` in 1: consumer accepts the offered event.
- `Overflow_Clr` in 1: synchronous pulse that clears all overflow flags.
- `Event_Valid` out 1: an event is offered.
- `Event_Id` out `ID_W`: index of the offered input.
- `Pending` out `Width`: pending flags.
- `Overflow` out `Width`: sticky overflow flags.

## Operation
- **Edge stage.** The delay register `lvl_q` is loaded with `Level_In` on every clock, regardless of `enable`.
  - `edge = Level_In & ~lvl_q & {Width{enable}}`.
  - Reset value of `lvl_q` is all ones, so an input already high when reset releases produces no event.
  - Re-enabling the block while an input is held high produces no event for it.
- **Pending.** `Pending[i]` is set when `edge[i]` is high, and cleared when event `i` completes its handshake.
  - Setting has priority over the handshake clear and over `clear_pending`.
- **Overflow.** `Overflow[i]` is set when `edge[i]` is high, `Pending[i]` is already 1, and pending `i` is not being cleared by a handshake in the same cycle.
  - `Overflow_Clr` clears all overflow flags; a new overflow in the same cycle wins.
- **Round-robin selection.** Pointer `rr_ptr` has width `ID_W` and resets to 0.
  - The winner is the first set `Pending` bit, searching from `rr_ptr` upward and wrapping at `Width-1`.
- **FSM states.** `IDLE` and `OFFER`; reset state is `IDLE`.
- `IDLE`:
  - If `Pending` is nonzero and `clear_pending` is low: latch the winner into `Event_Id` and go to `OFFER`.
  - Otherwise stay in `IDLE`.
- `OFFER`: `Event_Valid` = 1, and `Event_Id` is held stable.
  - If `Event_Valid & Event_Ready`: clear `Pending[Event_Id]` (unless set again in the same cycle), set `rr_ptr = (Event_Id+1) mod Width`, and go to `IDLE`.
  - If `clear_pending` is high: drop `Event_Valid` and go to `IDLE`. This deliberate abort is the only case in which `Valid` falls without `Ready`. `rr_ptr` is unchanged.
  - `clear_pending` together with `Ready` in the same cycle: the handshake completes (the pointer advances) and all pending flags are cleared.
- **Reset values.** `Event_Valid` = 0, `Event_Id` = 0, `Pending` = 0, `Overflow` = 0, `rr_ptr` = 0, `lvl_q` = all ones.
- **Width = 1.** `Event_Id` is constantly 0 and `rr_ptr` stays 0.

## Timing
- **Latency.** `Level_In[i]` is first sampled high at edge k, so `Pending[i]` = 1 after edge k. `Event_Valid` = 1 after edge k+1.
- **Throughput.** At most one event every 2 cycles; the `IDLE` state is a mandatory bubble after every handshake.
- **Handshake.** The transfer happens at a rising edge where `Valid` and `Ready` are both high. `Ready` may be asserted before `Valid`. The consumer must not depend on `Ready` combinationally from `Valid`.
- **Async reset.** Asserting `ares_n` low mid-offer drops `Event_Valid` immediately, with no clock required. Release is synchronized externally.

## Structure
- **Shared package `edge_event_pkg`:**
  - state enum {`IDLE`, `OFFER`};
  - function `id_width(Width)` returning max(1, clog2(`Width`)).
- **Sub-module `rr_pick`.** Combinational round-robin priority selector.
  - Inputs: `req[Width]`, `ptr[ID_W]`.
  - Outputs: `any`, `idx[ID_W]`.
  - It is reused by other arbiters.
- The edge stage, flags and FSM live in the top level.

## Test plan
- **Basic path.** `Width`=4, `Ready`=1; rise `Level_In[2]` before edge 10 → `Pending` = 4'b0100 after edge 10; `Valid`=1 with `Id`=2 after edge 11; `Pending`=0 and `Valid`=0 after edge 12.
- **Round robin.** Raise inputs 0, 1 and 3 at the same edge, `Ready`=1 → IDs come out 0, 1, 3, one every 2 cycles. Then re-raise input 0 while `rr_ptr`=0 → `Id` 0 is served next.
- **Backpressure.** `Ready`=0 for 5 cycles with `Id`=1 offered → `Valid` and `Id` stay stable. A second edge on input 1 sets `Overflow` to 4'b0010. An edge on input 1 in the same cycle as the handshake → `Pending[1]` stays 1 and no new overflow is flagged.
- **Enable and reset gating.**
  - `Level_In` = 4'hF held through reset → no events after release.
  - `enable`=0 while input 3 rises, then `enable`=1 with input 3 still high → no event.
- **Clear and abort.** `clear_pending` pulsed during an `OFFER` of `Id` 2 → `Valid`=0 next cycle, `Pending`=0, `rr_ptr` unchanged. `Overflow_Clr` in the same cycle as a new overflow → that overflow bit is set.
- **Async reset.** Assert `ares_n` low mid-`OFFER` between clock edges → all outputs are 0 immediately; after release, the bench repeats the basic path with the same latency.
